// File: rtl/cia_timer_ctrl.sv
// cia_timer_ctrl -- CRA/CRB control-register sequencer for CIA timers A and B.
//
// Holds both control registers and derives the per-timer control bundles
// (start, count, force_load, toggle) consumed by the two cia_timer instances.
// All state advances only on the phi2_dn strobe; reset is synchronous, active-low.
//
// Optional feature macro: CIA_TIMER_CASCADE_EN
//   defined   : CRB INMODE 10/11 count timer A underflows (cascade).
//   undefined : CRB bit 6 is not stored (reads 0); modes 10/11 act as 00/01.
//
// Ports:
//   clk, res_n        clock, synchronous active-low reset
//   phi2_dn           one-clk strobe at PHI2 falling edge (state update enable)
//   cra_w, crb_w      control register write strobes (qualified by phi2_dn)
//   data[7:0]         register write data
//   cnt               synchronised CNT pin
//   ufl_a, ufl_b      timer underflow flags (combinational from the timers)
//   cra, crb          control register read values
//   ctrl_a, ctrl_b    timer control bundles
//   pbon_a, pbon_b    PB6/PB7 timer output enables
//   spmode, todin     CRA bits 6/7 pass-through
//   alarm             CRB bit 7 pass-through

package cia;
  typedef struct packed {
    logic start;
    logic count;
    logic force_load;
    logic toggle;
  } tctrl_t;
endpackage

module cia_timer_ctrl (
  input  logic        clk,
  input  logic        res_n,
  input  logic        phi2_dn,
  input  logic        cra_w,
  input  logic        crb_w,
  input  logic [7:0]  data,
  input  logic        cnt,
  input  logic        ufl_a,
  input  logic        ufl_b,
  output logic [7:0]  cra,
  output logic [7:0]  crb,
  output cia::tctrl_t ctrl_a,
  output cia::tctrl_t ctrl_b,
  output logic        pbon_a,
  output logic        pbon_b,
  output logic        spmode,
  output logic        todin,
  output logic        alarm
);

  // LOAD (bit 4) is a strobe, never stored.
  localparam logic [7:0] CRA_MASK = 8'hEF;
`ifdef CIA_TIMER_CASCADE_EN
  localparam logic [7:0] CRB_MASK = 8'hEF;
`else
  localparam logic [7:0] CRB_MASK = 8'hAF;
`endif

  logic [7:0] cra_q, cra_d;
  logic [7:0] crb_q, crb_d;
  logic       fl_a_q, fl_a_d;
  logic       fl_b_q, fl_b_d;
  logic       cnt_q, cnt_d;
  logic       cnt_rise_q, cnt_rise_d;
  logic       src_a, src_b;

  always_comb begin
    cra_d      = cra_q;
    crb_d      = crb_q;
    fl_a_d     = fl_a_q;
    fl_b_d     = fl_b_q;
    cnt_d      = cnt_q;
    cnt_rise_d = cnt_rise_q;
    if (phi2_dn) begin
      cnt_d      = cnt;
      cnt_rise_d = cnt & ~cnt_q;
      fl_a_d     = cra_w & data[4];
      fl_b_d     = crb_w & data[4];
      // A register write in the same strobe overrides one-shot auto-stop.
      if (cra_w) begin
        cra_d = data & CRA_MASK;
      end else if (ufl_a && cra_q[3]) begin
        cra_d[0] = 1'b0;
      end
      if (crb_w) begin
        crb_d = data & CRB_MASK;
      end else if (ufl_b && crb_q[3]) begin
        crb_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      cra_q      <= '0;
      crb_q      <= '0;
      fl_a_q     <= 1'b0;
      fl_b_q     <= 1'b0;
      cnt_q      <= 1'b1;  // no spurious CNT edge straight after reset
      cnt_rise_q <= 1'b0;
    end else begin
      cra_q      <= cra_d;
      crb_q      <= crb_d;
      fl_a_q     <= fl_a_d;
      fl_b_q     <= fl_b_d;
      cnt_q      <= cnt_d;
      cnt_rise_q <= cnt_rise_d;
    end
  end

  always_comb begin
    src_a = cra_q[5] ? cnt_rise_q : 1'b1;
`ifdef CIA_TIMER_CASCADE_EN
    // Cascade modes use ufl_a combinationally: zero added latency into timer B.
    unique case (crb_q[6:5])
      2'b00:   src_b = 1'b1;
      2'b01:   src_b = cnt_rise_q;
      2'b10:   src_b = ufl_a;
      default: src_b = ufl_a & cnt_q;
    endcase
`else
    src_b = crb_q[5] ? cnt_rise_q : 1'b1;
`endif
  end

  always_comb begin
    ctrl_a.start      = cra_q[0];
    ctrl_a.count      = cra_q[0] & src_a;
    ctrl_a.force_load = fl_a_q;
    ctrl_a.toggle     = cra_q[2];
    ctrl_b.start      = crb_q[0];
    ctrl_b.count      = crb_q[0] & src_b;
    ctrl_b.force_load = fl_b_q;
    ctrl_b.toggle     = crb_q[2];
  end

  assign cra    = cra_q;
  assign crb    = crb_q;
  assign pbon_a = cra_q[1];
  assign pbon_b = crb_q[1];
  assign spmode = cra_q[6];
  assign todin  = cra_q[7];
  assign alarm  = crb_q[7];

endmodule

// File: tb/tb_cia_timer_ctrl.sv
// tb_cia_timer_ctrl -- scoreboard bench for cia_timer_ctrl.
// Each PHI2 period drives inputs, pushes the expected output vector for that
// period, compares it at two mid-period samples, then issues the phi2_dn strobe
// and advances the reference model.

module tb_cia_timer_ctrl;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        phi2_dn = 1'b0;
  logic        cra_w = 1'b0;
  logic        crb_w = 1'b0;
  logic [7:0]  data = '0;
  logic        cnt = 1'b0;
  logic        ufl_a = 1'b0;
  logic        ufl_b = 1'b0;
  logic [7:0]  cra, crb;
  cia::tctrl_t ctrl_a, ctrl_b;
  logic        pbon_a, pbon_b, spmode, todin, alarm;

  always #5 clk = ~clk;

  cia_timer_ctrl dut (
    .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .cra_w(cra_w), .crb_w(crb_w),
    .data(data), .cnt(cnt), .ufl_a(ufl_a), .ufl_b(ufl_b), .cra(cra), .crb(crb),
    .ctrl_a(ctrl_a), .ctrl_b(ctrl_b), .pbon_a(pbon_a), .pbon_b(pbon_b),
    .spmode(spmode), .todin(todin), .alarm(alarm)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned hits_a   = 0;
  int unsigned hits_b   = 0;
  logic [28:0] sb[$];

  // Reference model state
  logic [7:0] m_cra, m_crb;
  logic       m_fla, m_flb, m_cntq, m_rise;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [28:0] dut_vec();
    return {cra, crb,
            ctrl_a.start, ctrl_a.count, ctrl_a.force_load, ctrl_a.toggle,
            ctrl_b.start, ctrl_b.count, ctrl_b.force_load, ctrl_b.toggle,
            pbon_a, pbon_b, spmode, todin, alarm};
  endfunction

  task automatic model_reset();
    m_cra = '0; m_crb = '0; m_fla = 1'b0; m_flb = 1'b0; m_cntq = 1'b1; m_rise = 1'b0;
  endtask

  function automatic logic [28:0] model_out(input logic ua);
    logic [3:0] ca, cb;
    logic       sa, sbb;
    sa = m_cra[5] ? m_rise : 1'b1;
`ifdef CIA_TIMER_CASCADE_EN
    case (m_crb[6:5])
      2'b00:   sbb = 1'b1;
      2'b01:   sbb = m_rise;
      2'b10:   sbb = ua;
      default: sbb = ua & m_cntq;
    endcase
`else
    sbb = m_crb[5] ? m_rise : 1'b1;
`endif
    ca = {m_cra[0], m_cra[0] & sa, m_fla, m_cra[2]};
    cb = {m_crb[0], m_crb[0] & sbb, m_flb, m_crb[2]};
    return {m_cra, m_crb, ca, cb, m_cra[1], m_crb[1], m_cra[6], m_cra[7], m_crb[7]};
  endfunction

  task automatic model_strobe(input logic w_a, input logic w_b, input logic [7:0] d,
                              input logic c, input logic ua, input logic ub);
    m_rise = c & ~m_cntq;
    m_cntq = c;
    m_fla  = w_a & d[4];
    m_flb  = w_b & d[4];
    if (w_a) m_cra = {d[7:5], 1'b0, d[3:0]};
    else if (ua && m_cra[3]) m_cra[0] = 1'b0;
`ifdef CIA_TIMER_CASCADE_EN
    if (w_b) m_crb = {d[7:5], 1'b0, d[3:0]};
`else
    if (w_b) m_crb = {d[7], 1'b0, d[5], 1'b0, d[3:0]};
`endif
    else if (ub && m_crb[3]) m_crb[0] = 1'b0;
  endtask

  // One PHI2 period: drive, predict, sample twice, strobe.
  task automatic period(input string tag, input logic rn, input logic w_a, input logic w_b,
                        input logic [7:0] d, input logic c, input logic ua, input logic ub);
    logic [28:0] e;
    res_n = rn; phi2_dn = 1'b0;
    cra_w = w_a; crb_w = w_b; data = d; cnt = c; ufl_a = ua; ufl_b = ub;
    if (!rn) model_reset();
    e = model_out(ua);
    sb.push_back(e);
    sb.push_back(e);
    repeat (2) begin
      @(negedge clk);
      if (sb.size() == 0) check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
      else check_eq(tag, {3'b0, dut_vec()}, {3'b0, sb.pop_front()});
    end
    hits_a += int'(ctrl_a.count);
    hits_b += int'(ctrl_b.count);
    phi2_dn = 1'b1;
    @(negedge clk);
    phi2_dn = 1'b0;
    if (rn) model_strobe(w_a, w_b, d, c, ua, ub);
  endtask

  task automatic idle(input string tag, input logic c, input logic ua);
    period(tag, 1'b1, 1'b0, 1'b0, 8'h00, c, ua, 1'b0);
  endtask

  logic cnt_seq[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic ua_seq[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    model_reset();
    @(negedge clk);
    // Reset held across two strobes
    period("reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    period("reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("rst_cra", {24'b0, cra}, 32'h00);
    check_eq("rst_crb", {24'b0, crb}, 32'h00);

    // Start + force load in one write
    period("wr_11", 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
    check_eq("cra_rd01", {24'b0, cra}, 32'h01);
    check_eq("fl_set", {31'b0, ctrl_a.force_load}, 32'd1);
    idle("run_a", 1'b0, 1'b0);
    check_eq("fl_clr", {31'b0, ctrl_a.force_load}, 32'd0);
    hits_a = 0;
    repeat (3) idle("run_a", 1'b0, 1'b0);
    check_eq("phi2_count", hits_a, 32'd3);

    // CNT edge counting
    period("wr_21", 1'b1, 1'b1, 1'b0, 8'h21, 1'b0, 1'b0, 1'b0);
    hits_a = 0;
    for (int i = 0; i < 6; i++) idle("cnt_edge", cnt_seq[i], 1'b0);
    check_eq("cnt_edges", hits_a, 32'd2);

    // One-shot auto-stop, then write overriding it
    period("wr_09", 1'b1, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0);
    idle("oneshot", 1'b0, 1'b0);
    idle("oneshot_ufl", 1'b0, 1'b1);
    check_eq("oneshot_cra", {24'b0, cra}, 32'h08);
    check_eq("oneshot_cnt", {31'b0, ctrl_a.count}, 32'd0);
    period("wr_09b", 1'b1, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0);
    period("wr_ufl", 1'b1, 1'b1, 1'b0, 8'h09, 1'b0, 1'b1, 1'b0);
    check_eq("wr_wins", {24'b0, cra}, 32'h09);

    // Reset aborts a pending force load
    period("wr_11r", 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
    period("mid_rst", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("rst_fl", {31'b0, ctrl_a.force_load}, 32'd0);

    // Pass-through bits and timer B one-shot
    period("wr_cra_c0", 1'b1, 1'b1, 1'b0, 8'hC6, 1'b0, 1'b0, 1'b0);
    period("wr_crb_80", 1'b1, 1'b0, 1'b1, 8'h8B, 1'b0, 1'b0, 1'b0);
    period("b_oneshot", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("b_stop", {24'b0, crb}, 32'h8A);

`ifdef CIA_TIMER_CASCADE_EN
    period("wr_41", 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    hits_b = 0;
    for (int i = 0; i < 6; i++) idle("casc", 1'b0, ua_seq[i]);
    check_eq("casc_hits", hits_b, 32'd3);
    period("wr_61", 1'b1, 1'b0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    hits_b = 0;
    repeat (4) idle("casc_lo", 1'b0, 1'b1);
    check_eq("casc_cnt_lo", hits_b, 32'd0);
    hits_b = 0;
    idle("casc_hi", 1'b1, 1'b0);
    idle("casc_hi", 1'b1, 1'b1);
    check_eq("casc_cnt_hi", hits_b, 32'd1);
`else
    period("wr_41", 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    check_eq("crb_rd01", {24'b0, crb}, 32'h01);
    hits_b = 0;
    for (int i = 0; i < 4; i++) idle("no_casc", 1'b0, ua_seq[i + 1]);
    check_eq("no_casc_hits", hits_b, 32'd4);
`endif

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      period("rand", ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cia_timer_ctrl.md
# cia_timer_ctrl

Control-register sequencer for the two interval timers (A and B) of the CIA. Holds CRA/CRB and generates the per-timer `cia::tctrl_t` control bundles (start, count, force_load, toggle) that drive the two `cia_timer` instances. It also:
- selects each timer's count source;
- implements one-shot auto-stop;
- issues the self-clearing force-load strobe;
- cascades timer A underflows into timer B.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock. Everything below is synchronous to `clk`.
- `res_n` in 1: reset, synchronous, active-low.
- `phi2_dn` in 1: one-`clk` strobe marking the falling edge of PHI2. All state updates only on this strobe.
- `cra_w` in 1: write strobe for CRA, valid with `phi2_dn`.
- `crb_w` in 1: write strobe for CRB, valid with `phi2_dn`.
- `data` in 8: register write data.
- `cnt` in 1: CNT pin, already synchronised.
- `ufl_a` in 1: timer A underflow. Combinational from timer A in the same cycle.
- `ufl_b` in 1: timer B underflow.
- `cra` out 8: CRA read value.
- `crb` out 8: CRB read value.
- `ctrl_a` out `cia::tctrl_t`: timer A control.
- `ctrl_b` out `cia::tctrl_t`: timer B control.
- `pbon_a` out 1: timer A output enable on PB6.
- `pbon_b` out 1: timer B output enable on PB7.
- `spmode` out 1: CRA bit 6, passed through to the serial port.
- `todin` out 1: CRA bit 7, passed through to the TOD block.
- `alarm` out 1: CRB bit 7, passed through to the TOD block.

## Operation
CRA bit map:
- bit 0 START
- bit 1 PBON
- bit 2 OUTMODE (1 = toggle)
- bit 3 RUNMODE (1 = one-shot)
- bit 4 LOAD
- bit 5 INMODE: 0 = PHI2, 1 = CNT rising edge
- bit 6 SPMODE
- bit 7 TODIN

CRB bit map:
- bits 0–4 as CRA
- bits 6:5 INMODE: 00 = PHI2, 01 = CNT rising edge, 10 = timer A underflow, 11 = timer A underflow while CNT high
- bit 7 ALARM

Register behaviour:
- Control register write: on `phi2_dn & cra_w` (or `crb_w`), store `data`. Bit 4 is not stored and always reads 0.
- Force load: `ctrl_x.force_load` = 1 for exactly one `phi2_dn` period following a write with bit 4 set, then 0.
- Start: `ctrl_x.start` = stored START bit.
- Toggle: `ctrl_x.toggle` = OUTMODE.
- PB enable: `pbon_x` = PBON.

Count enable:
- INMODE PHI2: `count` = START.
- INMODE CNT: `count` = START & `cnt_rise`. `cnt_rise` is registered at `phi2_dn` as `cnt & ~cnt_q`, where `cnt_q` is the previous sampled `cnt`.
- INMODE 10: `ctrl_b.count` = START_B & `ufl_a`, combinational.
- INMODE 11: `ctrl_b.count` = START_B & `ufl_a` & `cnt_q`, combinational.

One-shot auto-stop:
- On `phi2_dn` with `ufl_x` = 1 and RUNMODE = 1, START_x is cleared.
- If a CR write happens in the same `phi2_dn`, the written START value wins.

Timer independence: timer A and timer B are independent except for the cascade path.

## Timing
- Reset (`res_n` = 0 at a `clk` edge, regardless of `phi2_dn`):
  - `cra` = `crb` = 0x00.
  - All `ctrl_*` fields = 0; `pbon_*`, `spmode`, `todin`, `alarm` = 0.
  - `cnt_q` = 1, so there is no false edge after reset.
  - `cnt_rise` = 0.
  - Reset mid-count aborts a pending force_load strobe.
- Write latency:
  - A CR write at `phi2_dn` k is visible on `cra`/`crb` and `ctrl_*` from the `clk` after k.
  - The force_load pulse spans k+1 to the next `phi2_dn`.
- CNT edge: a rising edge sampled at `phi2_dn` k gives `count` = 1 for the period k → k+1 only. The CNT level must be held across two samples to produce a second edge.
- Cascade: zero added latency. `ufl_a` and `ctrl_b.count` are in the same period.
- One-shot: an underflow sampled at `phi2_dn` k clears START at k. `ctrl_x.start` = 0 from k+1. `count` drops in the same `clk` as `start`.
- Force load with START = 1 in the same write: start and force_load both assert from k+1.
- Outputs change only on `clk` edges where `phi2_dn` = 1 or `res_n` = 0.

## Configuration
`CIA_TIMER_CASCADE_EN` controls timer B cascade.
- Defined: CRB INMODE 10/11 behave as above.
- Undefined:
  - CRB bit 6 is not stored and reads 0.
  - Modes 10/11 degrade to 00/01.
  - `ufl_a` is unused by the timer B path.

## Test plan
- Reset: hold `res_n` = 0 for 2 `phi2_dn` → `cra` = `crb` = 0x00, all `ctrl_*` = 0, `pbon_*` = 0.
- Write CRA = 0x11 → `ctrl_a.start` = 1, `force_load` = 1 for exactly one period, `cra` reads 0x01, `ctrl_a.count` = 1 every period.
- CRA = 0x21, toggle `cnt` 0,1,1,0,1 over 5 `phi2_dn` → `ctrl_a.count` = 1 in exactly 2 periods, the ones after each rising sample.
- CRA = 0x09 and assert `ufl_a` at period k → START cleared, `cra` = 0x08 and `ctrl_a.count` = 0 from k+1. Repeat with a `cra_w` of 0x09 at k → START remains 1.
- With `CIA_TIMER_CASCADE_EN`: CRB = 0x41, pulse `ufl_a` 3 times → `ctrl_b.count` high in exactly those 3 periods. CRB = 0x61 with `cnt` = 0 → `ctrl_b.count` stays 0.
- Without `CIA_TIMER_CASCADE_EN`: write CRB = 0x41 → `crb` reads 0x01, `ctrl_b.count` = 1 every period, independent of `ufl_a`.
